// File: rtl/dcpu16_marb.sv
// Memory arbiter: serialises the F-BUS (read/write) and G-BUS (read-only) masters
// onto one single-port synchronous RAM, returning a one-cycle ack per transfer.
module dcpu16_marb #(
    parameter int unsigned AW   = 16,
    parameter int unsigned DW   = 16,
    parameter int unsigned WAIT = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] f_adr,
    input  logic          f_stb,
    input  logic          f_wre,
    input  logic [DW-1:0] f_dto,
    output logic [DW-1:0] f_dti,
    output logic          f_ack,
    input  logic [AW-1:0] g_adr,
    input  logic          g_stb,
    output logic [DW-1:0] g_dti,
    output logic          g_ack,
    output logic [AW-1:0] m_adr,
    output logic [DW-1:0] m_dto,
    output logic          m_en,
    output logic          m_we,
    input  logic [DW-1:0] m_dti
);

    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MEM,
        S_WAIT,
        S_ACK
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          gnt_g, gnt_g_nx;
    logic          last_g, last_g_nx;
    logic [AW-1:0] adr_nx;
    logic [DW-1:0] dto_nx;
    logic          en_nx, we_nx, f_ack_nx, g_ack_nx;

    // Read data is shared; each master only looks at it in its own ack cycle.
    assign f_dti = m_dti;
    assign g_dti = m_dti;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            gnt_g  <= 1'b0;
            last_g <= 1'b1;
            m_adr  <= '0;
            m_dto  <= '0;
            m_en   <= 1'b0;
            m_we   <= 1'b0;
            f_ack  <= 1'b0;
            g_ack  <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            gnt_g  <= gnt_g_nx;
            last_g <= last_g_nx;
            m_adr  <= adr_nx;
            m_dto  <= dto_nx;
            m_en   <= en_nx;
            m_we   <= we_nx;
            f_ack  <= f_ack_nx;
            g_ack  <= g_ack_nx;
        end
    end

    // Outputs are computed for the state being entered so they register in step with it.
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        gnt_g_nx  = gnt_g;
        last_g_nx = last_g;
        adr_nx    = m_adr;
        dto_nx    = m_dto;
        en_nx     = 1'b0;
        we_nx     = 1'b0;
        f_ack_nx  = 1'b0;
        g_ack_nx  = 1'b0;

        case (state)
            S_IDLE: begin
                if (f_stb || g_stb) begin
                    // On a tie the master that was not served last wins.
                    gnt_g_nx  = (f_stb && g_stb) ? !last_g : g_stb;
                    last_g_nx = gnt_g_nx;
                    adr_nx    = gnt_g_nx ? g_adr : f_adr;
                    dto_nx    = f_dto;
                    en_nx     = 1'b1;
                    we_nx     = !gnt_g_nx && f_wre;
                    state_nx  = S_MEM;
                end
            end
            S_MEM: begin
                cnt_nx = CW'(WAIT);
                if (WAIT == 0) begin
                    state_nx = S_ACK;
                    f_ack_nx = !gnt_g;
                    g_ack_nx = gnt_g;
                end else begin
                    state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_nx = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    state_nx = S_ACK;
                    f_ack_nx = !gnt_g;
                    g_ack_nx = gnt_g;
                end
            end
            S_ACK: begin
                state_nx = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dcpu16_marb.sv
// Directed and random bench for dcpu16_marb, checked against a transaction-level
// model of the arbiter (serial service, fixed latency, alternate-on-tie).
module tb_dcpu16_marb;

    localparam int unsigned W0 = 0;
    localparam int unsigned W3 = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] f_adr, f_dto, f_dti, g_adr, g_dti, m_adr, m_dto, m_dti;
    logic        f_stb, f_wre, f_ack, g_stb, g_ack, m_en, m_we;

    logic [15:0] g3_adr, f3_dti, g3_dti, m3_adr, m3_dto, m3_dti;
    logic        g3_stb, f3_ack, g3_ack, m3_en, m3_we;

    logic        ram_init, bd_we;
    logic [7:0]  bd_adr;
    logic [15:0] bd_dat;
    logic [15:0] ram [256];
    logic [15:0] ref_mem [256];

    int errors = 0;
    int checks = 0;

    int          cyc, free_cyc, mem_cyc, ack_cyc;
    logic        mdl_g, mdl_we, mdl_last_g;
    logic [15:0] mdl_adr, mdl_dto, mdl_rd;

    always #5 clk = ~clk;

    dcpu16_marb #(.AW(16), .DW(16), .WAIT(W0)) dut (
        .clk(clk), .rst(rst),
        .f_adr(f_adr), .f_stb(f_stb), .f_wre(f_wre), .f_dto(f_dto), .f_dti(f_dti), .f_ack(f_ack),
        .g_adr(g_adr), .g_stb(g_stb), .g_dti(g_dti), .g_ack(g_ack),
        .m_adr(m_adr), .m_dto(m_dto), .m_en(m_en), .m_we(m_we), .m_dti(m_dti)
    );

    dcpu16_marb #(.AW(16), .DW(16), .WAIT(W3)) dut3 (
        .clk(clk), .rst(rst),
        .f_adr(16'h0000), .f_stb(1'b0), .f_wre(1'b0), .f_dto(16'h0000), .f_dti(f3_dti), .f_ack(f3_ack),
        .g_adr(g3_adr), .g_stb(g3_stb), .g_dti(g3_dti), .g_ack(g3_ack),
        .m_adr(m3_adr), .m_dto(m3_dto), .m_en(m3_en), .m_we(m3_we), .m_dti(m3_dti)
    );

    function automatic logic [15:0] init_val(input logic [7:0] a);
        return {a, ~a} ^ 16'h3C00;
    endfunction

    function automatic logic [15:0] rnd_adr();
        logic [15:0] a;
        a = 16'($urandom);
        a[7:4] = 4'h0;
        return a;
    endfunction

    // 256-word registered RAM; read data holds while m_en is low.
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 256; i++) ram[i] <= init_val(8'(i));
        end else if (bd_we) begin
            ram[bd_adr] <= bd_dat;
        end
        if (m_en) begin
            if (m_we) ram[m_adr[7:0]] <= m_dto;
            m_dti <= ram[m_adr[7:0]];
        end
    end

    always @(posedge clk) begin
        if (m3_en) m3_dti <= init_val(m3_adr[7:0]);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    // Model decides on the inputs of the current cycle, then one clock passes and outputs are checked.
    task automatic step();
        if (rst) begin
            mdl_last_g = 1'b1;
            free_cyc   = cyc + 1;
            mem_cyc    = -1;
            ack_cyc    = -1;
        end else if (cyc >= free_cyc && (f_stb || g_stb)) begin
            mdl_g      = (f_stb && g_stb) ? !mdl_last_g : g_stb;
            mdl_last_g = mdl_g;
            mdl_adr    = mdl_g ? g_adr : f_adr;
            mdl_we     = !mdl_g && f_wre;
            mdl_dto    = f_dto;
            mdl_rd     = ref_mem[mdl_adr[7:0]];
            if (mdl_we) ref_mem[mdl_adr[7:0]] = mdl_dto;
            mem_cyc  = cyc + 1;
            ack_cyc  = cyc + 2 + int'(W0);
            free_cyc = cyc + 3 + int'(W0);
        end
        @(posedge clk);
        #1;
        cyc++;
        chk("f_ack", 32'(f_ack), 32'(cyc == ack_cyc && !mdl_g));
        chk("g_ack", 32'(g_ack), 32'(cyc == ack_cyc && mdl_g));
        chk("m_en", 32'(m_en), 32'(cyc == mem_cyc));
        if (cyc == mem_cyc) begin
            chk("m_adr", 32'(m_adr), 32'(mdl_adr));
            chk("m_we", 32'(m_we), 32'(mdl_we));
            if (mdl_we) chk("m_dto", 32'(m_dto), 32'(mdl_dto));
        end
        if (cyc == ack_cyc && !mdl_we)
            chk(mdl_g ? "g_dti" : "f_dti", 32'(mdl_g ? g_dti : f_dti), 32'(mdl_rd));
    endtask

    initial begin
        int ena_cnt, reads;
        cyc = 0; free_cyc = 0; mem_cyc = -1; ack_cyc = -1;
        mdl_g = 1'b0; mdl_we = 1'b0; mdl_last_g = 1'b1;
        mdl_adr = '0; mdl_dto = '0; mdl_rd = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));
        rst = 1'b1; ram_init = 1'b1; bd_we = 1'b0; bd_adr = '0; bd_dat = '0;
        f_stb = 1'b0; f_wre = 1'b0; f_adr = '0; f_dto = '0;
        g_stb = 1'b0; g_adr = '0; g3_stb = 1'b0; g3_adr = '0;
        step();
        ram_init = 1'b0;
        bd_we = 1'b1; bd_adr = 8'h10; bd_dat = 16'hBEEF; ref_mem[8'h10] = 16'hBEEF;
        step();
        bd_we = 1'b0;
        chk("rst_m_en", 32'(m_en), 32'(0));
        chk("rst_m_we", 32'(m_we), 32'(0));
        chk("rst_m_adr", 32'(m_adr), 32'(0));
        chk("rst_m_dto", 32'(m_dto), 32'(0));
        chk("rst_m3_en", 32'(m3_en), 32'(0));

        // 1: single G read
        rst = 1'b0; g_stb = 1'b1; g_adr = 16'h0010;
        for (int k = 1; k <= 3; k++) begin
            step();
            chk("t1_g_ack", 32'(g_ack), 32'(k == 2));
            if (k == 1) chk("t1_m_adr", 32'(m_adr), 32'h0010);
            if (k == 2) begin
                chk("t1_g_dti", 32'(g_dti), 32'hBEEF);
                g_stb = 1'b0;
            end
        end

        // 2: F write then F read of the same word
        f_stb = 1'b1; f_wre = 1'b1; f_adr = 16'h00FF; f_dto = 16'h1234;
        for (int k = 1; k <= 5; k++) begin
            step();
            chk("t2_f_ack", 32'(f_ack), 32'(k == 2 || k == 5));
            if (k == 1) chk("t2_m_we", 32'(m_we), 32'(1));
            if (k == 2) f_wre = 1'b0;
            if (k == 4) chk("t2_m_we_rd", 32'(m_we), 32'(0));
            if (k == 5) begin
                chk("t2_f_dti", 32'(f_dti), 32'h1234);
                f_stb = 1'b0;
            end
        end

        // 3: both requesting from reset alternate F, G, F, G
        rst = 1'b1;
        step();
        rst = 1'b0;
        f_stb = 1'b1; f_wre = 1'b0; f_adr = 16'h0001; g_stb = 1'b1; g_adr = 16'h0002;
        for (int k = 1; k <= 11; k++) begin
            step();
            chk("t3_f_ack", 32'(f_ack), 32'(k == 2 || k == 8));
            chk("t3_g_ack", 32'(g_ack), 32'(k == 5 || k == 11));
            if (k == 11) begin
                f_stb = 1'b0; g_stb = 1'b0;
            end
        end

        // 4: three wait-states on the second instance
        g3_stb = 1'b1; g3_adr = 16'hA234;
        for (int k = 1; k <= 6; k++) begin
            step();
            chk("t4_m3_en", 32'(m3_en), 32'(k == 1));
            chk("t4_g3_ack", 32'(g3_ack), 32'(k == 5));
            chk("t4_f3_ack", 32'(f3_ack), 32'(0));
            if (k == 1) begin
                chk("t4_m3_adr", 32'(m3_adr), 32'hA234);
                chk("t4_m3_we", 32'(m3_we), 32'(0));
                chk("t4_m3_dto", 32'(m3_dto), 32'(0));
            end
            if (k == 5) begin
                chk("t4_g3_dti", 32'(g3_dti), 32'(init_val(8'h34)));
                chk("t4_f3_dti", 32'(f3_dti), 32'(init_val(8'h34)));
                g3_stb = 1'b0;
            end
        end

        // 5: reset during the MEM cycle of an F write abandons it
        f_stb = 1'b1; f_wre = 1'b1; f_adr = 16'h0040; f_dto = 16'hCAFE;
        step();
        chk("t5_m_we", 32'(m_we), 32'(1));
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t5_rst_m_en", 32'(m_en), 32'(0));
        chk("t5_rst_m_we", 32'(m_we), 32'(0));
        chk("t5_rst_m_adr", 32'(m_adr), 32'(0));
        chk("t5_rst_f_ack", 32'(f_ack), 32'(0));
        step();
        chk("t5_f_ack_early", 32'(f_ack), 32'(0));
        step();
        chk("t5_f_ack", 32'(f_ack), 32'(1));
        f_stb = 1'b0;
        step();

        // 6: upstream stall term releases once per access
        ena_cnt = 0; reads = 0;
        g_stb = 1'b1; g_adr = rnd_adr();
        for (int k = 0; k < 40 && g_stb; k++) begin
            step();
            if (g_stb && (g_stb ~^ g_ack)) ena_cnt++;
            if (g_ack) begin
                reads++;
                if (reads == 4) g_stb = 1'b0;
                else g_adr = rnd_adr();
            end
        end
        if (g_stb) begin
            chk("t6_timeout", 32'(g_stb), 32'(0));
            g_stb = 1'b0;
        end
        chk("t6_ena_cnt", 32'(ena_cnt), 32'(4));
        chk("t6_reads", 32'(reads), 32'(4));
        step();

        // Random traffic from both masters
        for (int i = 0; i < 600; i++) begin
            if (!f_stb && $urandom_range(0, 2) == 0) begin
                f_stb = 1'b1; f_wre = 1'($urandom_range(0, 1));
                f_adr = rnd_adr(); f_dto = 16'($urandom);
            end
            if (!g_stb && $urandom_range(0, 2) == 0) begin
                g_stb = 1'b1; g_adr = rnd_adr();
            end
            step();
            if (cyc == ack_cyc) begin
                if (mdl_g) g_stb = 1'b0;
                else f_stb = 1'b0;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
